piso_serializer: RTL

//  Parallel-in/serial-out stage sitting directly upstream of the dff bit register:

---
 rtl/piso_serializer.sv | 74 +++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: handshaked parallel-in/serial-out shifter with first/last-bit frame markers,
// streaming back-to-back words without an idle gap.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pause,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             last, accept, advance;

    assign last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign load_ready = ~reset & ~pause & ((state == IDLE) | last);
    assign accept     = load_valid & load_ready;
    assign advance    = ~pause & (state == SHIFT) & ~last;
    assign busy       = (state == SHIFT);

    always_comb begin
        state_n = state;
        state_n = accept ? SHIFT : (~pause & last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sreg        <= '0;
            sout        <= IDLE_LEVEL;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                // the first bit leaves immediately; sreg keeps the remaining bits at the shift-out end
                cnt         <= '0;
                sout        <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
                sreg        <= MSB_FIRST ? (load_data << 1) : (load_data >> 1);
                sout_valid  <= 1'b1;
                frame_start <= 1'b1;
                frame_end   <= 1'b0;
            end else if (advance) begin
                cnt         <= cnt + CW'(1);
                sout        <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                sreg        <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                frame_start <= 1'b0;
                frame_end   <= (cnt == CW'(WIDTH - 2));
            end else if (~pause & last) begin
                cnt         <= '0;
                sout        <= IDLE_LEVEL;
                sout_valid  <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
            end
        end
    end
endmodule
